ext_pipe: RTL and testbench

EXT_PIPE -- requirements
Module: ext_pipe

---
 rtl/ext_pipe.sv | 86 ++++++++
 tb/tb_ext_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - immediate/load-lane extension unit with one registered output stage
// Decodes op, extends imm or a selected ldata byte/half to DW bits, flags illegal or misaligned requests.
module ext_pipe #(
  parameter int DW         = 32,
  parameter int IW         = 16,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  op,
  input  logic [IW-1:0]               imm,
  input  logic [DW-1:0]               ldata,
  input  logic [$clog2(DW/8)-1:0]     addr_lo,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW-1:0]               out_data,
  output logic                        out_err,
  output logic [7:0]                  err_cnt
);

  localparam int AW = $clog2(DW/8);
  localparam int NB = DW/8;

  logic [AW-1:0] byte_lane;
  logic [AW-1:0] half_lane;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [DW-1:0] res;
  logic          res_err;
  logic          accept;

  // Big-endian halves: the byte at addr_lo is the MSB and lands one lane above
  // the byte at addr_lo+1, so the pair base is NB-2-addr_lo. Bit 0 is forced
  // clear so a misaligned address never indexes past the word.
  always_comb begin
    byte_lane = BIG_ENDIAN ? (AW'(NB-1) - addr_lo) : addr_lo;
    half_lane = (BIG_ENDIAN ? (AW'(NB-2) - addr_lo) : addr_lo) & ~AW'(1);
    sel_byte  = ldata[{byte_lane, 3'b000} +: 8];
    sel_half  = ldata[{half_lane, 3'b000} +: 16];
  end

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (op)
      3'b000: res = {{(DW-IW){imm[IW-1]}}, imm};
      3'b001: res = {{(DW-IW){1'b0}}, imm};
      3'b010: res = {imm, {(DW-IW){1'b0}}};
      3'b011: res = {{(DW-8){sel_byte[7]}}, sel_byte};
      3'b100: res = {{(DW-8){1'b0}}, sel_byte};
      3'b101: begin
        if (addr_lo[0]) res_err = 1'b1;
        else            res     = {{(DW-16){sel_half[15]}}, sel_half};
      end
      3'b110: begin
        if (addr_lo[0]) res_err = 1'b1;
        else            res     = {{(DW-16){1'b0}}, sel_half};
      end
      default: res_err = 1'b1;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_err   <= res_err;
        if (res_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - self-checking bench for ext_pipe (DW=32, IW=16, big-endian)
// Directed scenarios followed by randomized traffic against a memory-view reference model.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] imm;
  logic [31:0] ldata;
  logic [1:0]  addr_lo;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;

  ext_pipe #(.DW(32), .IW(16), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .imm(imm), .ldata(ldata), .addr_lo(addr_lo),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] o, input logic [15:0] i, input logic [31:0] l, input logic [1:0] a);
    in_valid = 1'b1; op = o; imm = i; ldata = l; addr_lo = a;
  endtask

  // Big-endian memory view: address n holds word lane 3-n; a half at address n
  // is {mem[n], mem[n+1]}.
  function automatic void model(input logic [2:0] o, input logic [15:0] i, input logic [31:0] l,
                                input logic [1:0] a, output logic [31:0] d, output logic e);
    logic [7:0]  mem [4];
    logic [15:0] h;
    for (int n = 0; n < 4; n++) mem[n] = l[8*(3-n) +: 8];
    d = 32'd0;
    e = 1'b0;
    case (o)
      3'd0: d = 32'($signed(i));
      3'd1: d = {16'h0, i};
      3'd2: d = {i, 16'h0};
      3'd3: d = 32'($signed(mem[a]));
      3'd4: d = {24'h0, mem[a]};
      3'd5, 3'd6: begin
        if (a % 2 != 0) e = 1'b1;
        else begin
          h = {mem[a], mem[a+1]};
          d = (o == 3'd5) ? 32'($signed(h)) : {16'h0, h};
        end
      end
      default: e = 1'b1;
    endcase
  endfunction

  initial begin
    logic [31:0] held, md;
    logic        me, exp_valid, exp_err, exp_acc;
    logic [31:0] exp_data;
    int          exp_cnt;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; imm = 16'd0; ldata = 32'd0; addr_lo = 2'd0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    req(3'b000, 16'h8001, 32'd0, 2'd0);
    step();
    chk("sext_valid", out_valid, 1);
    chk("sext_data", out_data, 32'hFFFF8001);
    chk("sext_err", out_err, 0);

    req(3'b010, 16'h1234, 32'd0, 2'd0);
    step();
    chk("top_data", out_data, 32'h12340000);
    req(3'b001, 16'hF000, 32'd0, 2'd0);
    step();
    chk("zext_valid", out_valid, 1);
    chk("zext_data", out_data, 32'h0000F000);
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);

    req(3'b011, 16'd0, 32'h80FF7F01, 2'd0);
    step();
    chk("lb_data", out_data, 32'hFFFFFF80);
    req(3'b100, 16'd0, 32'h80FF7F01, 2'd1);
    step();
    chk("lbu_data", out_data, 32'h000000FF);
    req(3'b101, 16'd0, 32'h80FF7F01, 2'd2);
    step();
    chk("lh_data", out_data, 32'h00007F01);
    chk("lh_err", out_err, 0);

    req(3'b110, 16'd0, 32'h80FF7F01, 2'd1);
    step();
    chk("mis_data", out_data, 0);
    chk("mis_err", out_err, 1);
    chk("mis_cnt", err_cnt, 1);
    for (int n = 1; n <= 300; n++) begin
      req(3'b111, 16'($urandom), $urandom, 2'($urandom));
      step();
      if (n == 100) chk("cnt_mid", err_cnt, 101);
    end
    chk("ill_data", out_data, 0);
    chk("ill_err", out_err, 1);
    chk("cnt_sat", err_cnt, 255);

    req(3'b000, 16'h0005, 32'd0, 2'd0);
    step();
    held = out_data;
    chk("hold_first", held, 32'h00000005);
    out_ready = 1'b0;
    req(3'b001, 16'h7777, 32'd0, 2'd0);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, held);
    end
    out_ready = 1'b1;
    #1 chk("pop_in_ready", in_ready, 1);
    step();
    chk("replace_valid", out_valid, 1);
    chk("replace_data", out_data, 32'h00007777);
    in_valid = 1'b0;
    step();
    chk("no_dup_valid", out_valid, 0);

    req(3'b111, 16'd0, 32'd0, 2'd0);
    step();
    chk("pre_arst_valid", out_valid, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_cnt", err_cnt, 0);
    chk("arst_err", out_err, 0);
    #2 rst_n = 1'b1;
    step();
    chk("post_arst_valid", out_valid, 0);
    req(3'b000, 16'h7FFF, 32'd0, 2'd0);
    step();
    chk("post_arst_data", out_data, 32'h00007FFF);
    in_valid = 1'b0;
    step();

    exp_valid = 1'b0; exp_data = 32'd0; exp_err = 1'b0; exp_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(3, 0) != 0);
      op        = 3'($urandom);
      imm       = 16'($urandom);
      ldata     = $urandom;
      addr_lo   = 2'($urandom);
      #1;
      chk("rnd_in_ready", in_ready, !exp_valid || out_ready);
      exp_acc = in_valid && (!exp_valid || out_ready);
      if (exp_acc) begin
        model(op, imm, ldata, addr_lo, md, me);
        exp_valid = 1'b1; exp_data = md; exp_err = me;
        if (me && exp_cnt < 255) exp_cnt++;
      end else if (out_ready) begin
        exp_valid = 1'b0;
      end
      step();
      chk("rnd_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("rnd_data", out_data, exp_data);
        chk("rnd_err", out_err, exp_err);
      end
      chk("rnd_cnt", err_cnt, exp_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
